// File: rtl/intersection_phase_scheduler.sv
// Intersection phase scheduler: a Moore FSM that hands right-of-way between
// the highway (default owner), the country road and a pedestrian crossing,
// with yellow and all-red clearance phases and round-robin between country
// and pedestrian service when both are waiting.
// Optional build macro: TSC_PREEMPT_EN adds an emergency-preempt input that
// holds the highway green and cuts short country-green and walk phases.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN       = 4,
  parameter int MAX_CNTRY_GREEN = 8,
  parameter int WALK_TIME       = 6,
  parameter int TMR_W           = 4
) (
  input  logic       clock,
  input  logic       clear,
`ifdef TSC_PREEMPT_EN
  input  logic       preempt,
`endif
  input  logic       car_cntry,
  input  logic       ped_req,
  input  logic [2:0] y2rdelay,
  input  logic [2:0] r2gdelay,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_HG = 3'd0,
    ST_HY = 3'd1,
    ST_AR = 3'd2,
    ST_CG = 3'd3,
    ST_CY = 3'd4,
    ST_PW = 3'd5,
    ST_PC = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  localparam logic TGT_CNTRY = 1'b0;
  localparam logic TGT_PED   = 1'b1;

  // Last tmr value of each fixed-length phase (a phase of N cycles exits at N-1)
  localparam logic [TMR_W-1:0] L_MIN_GREEN_LAST = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] L_CG_LAST        = TMR_W'(MAX_CNTRY_GREEN - 1);
  localparam logic [TMR_W-1:0] L_WALK_LAST      = TMR_W'(WALK_TIME - 1);
  localparam logic [TMR_W-1:0] L_TMR_MAX        = '1;

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_tmr;
  logic             r_pedPending;
  logic             r_lastServed;
  logic             r_target;
  logic             w_targetNext;
  logic             w_preempt;
  logic [2:0]       w_yellowLast3;
  logic [2:0]       w_redLast3;
  logic [TMR_W-1:0] w_yellowLast;
  logic [TMR_W-1:0] w_redLast;
  logic             w_enterPw;
  logic             w_enterCg;

`ifdef TSC_PREEMPT_EN
  assign w_preempt = preempt;
`else
  assign w_preempt = 1'b0;
`endif

  // A programmed delay of 0 behaves as 1, so the last tmr value is delay-1 floored at 0
  assign w_yellowLast3 = (y2rdelay == 3'd0) ? 3'd0 : (y2rdelay - 3'd1);
  assign w_redLast3    = (r2gdelay == 3'd0) ? 3'd0 : (r2gdelay - 3'd1);
  assign w_yellowLast  = TMR_W'(w_yellowLast3);
  assign w_redLast     = TMR_W'(w_redLast3);

  assign w_enterPw = (w_next == ST_PW) && (r_state != ST_PW);
  assign w_enterCg = (w_next == ST_CG) && (r_state != ST_CG);

  // Next-state and service-target selection
  always_comb begin
    w_next       = r_state;
    w_targetNext = r_target;
    case (r_state)
      ST_HG: begin
        if (!w_preempt && (r_tmr >= L_MIN_GREEN_LAST) && (car_cntry || r_pedPending)) begin
          w_next = ST_HY;
          if (car_cntry && r_pedPending) begin
            w_targetNext = ~r_lastServed;
          end else if (r_pedPending) begin
            w_targetNext = TGT_PED;
          end else begin
            w_targetNext = TGT_CNTRY;
          end
        end
      end
      ST_HY: begin
        if (r_tmr >= w_yellowLast) w_next = ST_AR;
      end
      ST_AR: begin
        if (r_tmr >= w_redLast) begin
          if (w_preempt)                 w_next = ST_PC;
          else if (r_target == TGT_PED)  w_next = ST_PW;
          else                           w_next = ST_CG;
        end
      end
      ST_CG: begin
        if (w_preempt || !car_cntry || (r_tmr >= L_CG_LAST)) w_next = ST_CY;
      end
      ST_CY: begin
        if (r_tmr >= w_yellowLast) w_next = ST_PC;
      end
      ST_PW: begin
        if (w_preempt || (r_tmr >= L_WALK_LAST)) w_next = ST_PC;
      end
      ST_PC: begin
        if (r_tmr >= w_redLast) w_next = ST_HG;
      end
      default: w_next = ST_HG;
    endcase
  end

  // State register and in-state cycle timer that restarts on every transition
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_HG;
      r_tmr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_tmr <= '0;
      end else if (r_tmr != L_TMR_MAX) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
    end
  end

  // Pedestrian latch, service target and round-robin history
  always_ff @(posedge clock) begin
    if (clear) begin
      r_pedPending <= 1'b0;
      r_lastServed <= TGT_PED;
      r_target     <= TGT_CNTRY;
    end else begin
      r_target <= w_targetNext;
      if (w_enterPw) begin
        r_pedPending <= 1'b0;
      end else if (ped_req && (r_state != ST_PW)) begin
        r_pedPending <= 1'b1;
      end
      if (w_enterCg) begin
        r_lastServed <= TGT_CNTRY;
      end else if (w_enterPw) begin
        r_lastServed <= TGT_PED;
      end
    end
  end

  // Signal heads are a pure decode of the registered state
  always_comb begin
    hwy   = LAMP_RED;
    cntry = LAMP_RED;
    walk  = 1'b0;
    case (r_state)
      ST_HG:   hwy   = LAMP_GREEN;
      ST_HY:   hwy   = LAMP_YELLOW;
      ST_CG:   cntry = LAMP_GREEN;
      ST_CY:   cntry = LAMP_YELLOW;
      ST_PW:   walk  = 1'b1;
      default: ;
    endcase
  end

  assign phase       = r_state;
  assign ped_pending = r_pedPending;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed self-checking bench for intersection_phase_scheduler.
// Inputs change just after a falling edge and outputs are sampled on the
// falling edge, half a period away from the rising (active) edge.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] PH_HG = 3'd0;
  localparam logic [2:0] PH_HY = 3'd1;
  localparam logic [2:0] PH_AR = 3'd2;
  localparam logic [2:0] PH_CG = 3'd3;
  localparam logic [2:0] PH_CY = 3'd4;
  localparam logic [2:0] PH_PW = 3'd5;
  localparam logic [2:0] PH_PC = 3'd6;

  logic       clock = 1'b0;
  logic       clear;
  logic       car_cntry;
  logic       ped_req;
  logic [2:0] y2rdelay;
  logic [2:0] r2gdelay;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;
`ifdef TSC_PREEMPT_EN
  logic       preempt = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  intersection_phase_scheduler #(
    .MIN_GREEN(4), .MAX_CNTRY_GREEN(8), .WALK_TIME(6), .TMR_W(4)
  ) dut (
    .clock(clock),
    .clear(clear),
`ifdef TSC_PREEMPT_EN
    .preempt(preempt),
`endif
    .car_cntry(car_cntry),
    .ped_req(ped_req),
    .y2rdelay(y2rdelay),
    .r2gdelay(r2gdelay),
    .hwy(hwy),
    .cntry(cntry),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic car, input logic ped);
    car_cntry = car;
    ped_req   = ped;
  endtask

  // Check phase code and the head/walk values that phase must produce
  task automatic checkPhase(input string tag, input logic [2:0] ph);
    logic [1:0] expHwy;
    logic [1:0] expCntry;
    logic       expWalk;
    expHwy   = (ph == PH_HG) ? 2'd2 : (ph == PH_HY) ? 2'd1 : 2'd0;
    expCntry = (ph == PH_CG) ? 2'd2 : (ph == PH_CY) ? 2'd1 : 2'd0;
    expWalk  = (ph == PH_PW);
    checkOutput({tag, " phase"}, 8'(phase), 8'(ph));
    checkOutput({tag, " hwy"},   8'(hwy),   8'(expHwy));
    checkOutput({tag, " cntry"}, 8'(cntry), 8'(expCntry));
    checkOutput({tag, " walk"},  8'(walk),  8'(expWalk));
  endtask

  // Advance n falling edges, expecting the given phase at each one
  task automatic expectRun(input string tag, input int n, input logic [2:0] ph);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkPhase(tag, ph);
    end
  endtask

  initial begin
    clear    = 1'b1;
    y2rdelay = 3'd3;
    r2gdelay = 3'd2;
    applyStimulus(1'b0, 1'b0);

    // 1. Reset and idle
    repeat (5) @(negedge clock);
    checkPhase("reset", PH_HG);
    checkOutput("reset ped_pending", 8'(ped_pending), 8'd0);
    clear = 1'b0;
    expectRun("idle", 15, PH_HG);
    checkOutput("idle ped_pending", 8'(ped_pending), 8'd0);

    // 2. Short country service: car present 10 cycles
    applyStimulus(1'b1, 1'b0);
    expectRun("c1 HY", 3, PH_HY);
    expectRun("c1 AR", 2, PH_AR);
    expectRun("c1 CG", 5, PH_CG);
    applyStimulus(1'b0, 1'b0);
    expectRun("c1 CY", 3, PH_CY);
    expectRun("c1 PC", 2, PH_PC);
    expectRun("c1 HG", 1, PH_HG);

    // 3. Car held: country green capped at 8, highway regains green for 4
    applyStimulus(1'b1, 1'b0);
    expectRun("c2 HG", 3, PH_HG);
    expectRun("c2 HY", 3, PH_HY);
    expectRun("c2 AR", 2, PH_AR);
    expectRun("c2 CG", 8, PH_CG);
    expectRun("c2 CY", 3, PH_CY);
    expectRun("c2 PC", 2, PH_PC);
    expectRun("c2 HGmin", 4, PH_HG);
    expectRun("c3 HY", 1, PH_HY);
    applyStimulus(1'b0, 1'b0);
    expectRun("c3 HY", 2, PH_HY);
    expectRun("c3 AR", 2, PH_AR);
    expectRun("c3 CG1", 1, PH_CG);
    expectRun("c3 CY", 3, PH_CY);
    expectRun("c3 PC", 2, PH_PC);
    expectRun("c3 HG", 1, PH_HG);

    // 4. Single pedestrian pulse at tmr=3, ped_req during walk ignored
    expectRun("p1 HG", 3, PH_HG);
    applyStimulus(1'b0, 1'b1);
    expectRun("p1 HGlatch", 1, PH_HG);
    checkOutput("p1 latched", 8'(ped_pending), 8'd1);
    applyStimulus(1'b0, 1'b0);
    expectRun("p1 HY", 3, PH_HY);
    expectRun("p1 AR", 2, PH_AR);
    checkOutput("p1 held AR", 8'(ped_pending), 8'd1);
    expectRun("p1 PW", 1, PH_PW);
    checkOutput("p1 drop PW", 8'(ped_pending), 8'd0);
    applyStimulus(1'b0, 1'b1);
    expectRun("p1 PW", 1, PH_PW);
    applyStimulus(1'b0, 1'b0);
    expectRun("p1 PW", 4, PH_PW);
    checkOutput("p1 ignore in PW", 8'(ped_pending), 8'd0);
    expectRun("p1 PC", 2, PH_PC);
    expectRun("p1 HG", 1, PH_HG);
    checkOutput("p1 idle pending", 8'(ped_pending), 8'd0);

    // 5. Both requests after reset: country first, then walk, then country again
    clear = 1'b1;
    repeat (2) @(negedge clock);
    checkPhase("r2", PH_HG);
    checkOutput("r2 ped_pending", 8'(ped_pending), 8'd0);
    clear = 1'b0;
    applyStimulus(1'b1, 1'b1);
    expectRun("rr HG", 1, PH_HG);
    applyStimulus(1'b1, 1'b0);
    expectRun("rr HG", 2, PH_HG);
    expectRun("rr HY", 3, PH_HY);
    expectRun("rr AR", 2, PH_AR);
    expectRun("rr CG", 1, PH_CG);
    checkOutput("rr ped waits", 8'(ped_pending), 8'd1);
    applyStimulus(1'b0, 1'b0);
    expectRun("rr CY", 3, PH_CY);
    expectRun("rr PC", 2, PH_PC);
    expectRun("rr HGmin", 4, PH_HG);
    expectRun("rr HY2", 3, PH_HY);
    expectRun("rr AR2", 2, PH_AR);
    expectRun("rr PW", 6, PH_PW);
    expectRun("rr PC2", 2, PH_PC);
    expectRun("rr HG2", 1, PH_HG);
    applyStimulus(1'b1, 1'b1);
    expectRun("rr2 HG", 1, PH_HG);
    applyStimulus(1'b1, 1'b0);
    expectRun("rr2 HG", 2, PH_HG);
    expectRun("rr2 HY", 3, PH_HY);
    expectRun("rr2 AR", 2, PH_AR);
    expectRun("rr2 CG", 1, PH_CG);

    // 6. Zero delays act as one cycle; clear during country green
    applyStimulus(1'b0, 1'b0);
    y2rdelay = 3'd0;
    r2gdelay = 3'd0;
    expectRun("z CY", 1, PH_CY);
    expectRun("z PC", 1, PH_PC);
    expectRun("z HG", 4, PH_HG);
    expectRun("z HY", 1, PH_HY);
    expectRun("z AR", 1, PH_AR);
    expectRun("z PW", 6, PH_PW);
    expectRun("z PC2", 1, PH_PC);
    expectRun("z HG2", 1, PH_HG);
    applyStimulus(1'b1, 1'b0);
    expectRun("z HG2", 3, PH_HG);
    expectRun("z HY2", 1, PH_HY);
    expectRun("z AR2", 1, PH_AR);
    expectRun("z CG", 1, PH_CG);
    applyStimulus(1'b1, 1'b1);
    expectRun("z CG", 1, PH_CG);
    checkOutput("z ped latched", 8'(ped_pending), 8'd1);
    applyStimulus(1'b1, 1'b0);
    expectRun("z CG", 1, PH_CG);
    clear = 1'b1;
    expectRun("clear midCG", 1, PH_HG);
    checkOutput("clear ped_pending", 8'(ped_pending), 8'd0);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Phase scheduler for a highway/country-road intersection with a pedestrian crossing. Three requesters share the intersection: the highway (default owner), the country-road car sensor, and a latched pedestrian button. The block grants right-of-way through a Moore FSM with yellow and all-red clearance phases. It round-robins between country and pedestrian when both are pending, and drives the signal heads directly.

Parameters:
MIN_GREEN, 4, minimum highway-green cycles before any request is served (≥1)
MAX_CNTRY_GREEN, 8, maximum country-green cycles per service (≥1)
WALK_TIME, 6, walk-phase cycles (≥1)
TMR_W, 4, timer width; must hold max(MIN_GREEN, MAX_CNTRY_GREEN, WALK_TIME, 7)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
car_cntry  in  1  country-road car sensor, level
ped_req  in  1  pedestrian button, any-length pulse
y2rdelay  in  3  yellow duration in cycles (0 treated as 1)
r2gdelay  in  3  all-red clearance in cycles (0 treated as 1)
hwy  out  2  highway head: 0=RED, 1=YELLOW, 2=GREEN
cntry  out  2  country head, same encoding
walk  out  1  pedestrian WALK lamp
ped_pending  out  1  latched pedestrian request
phase  out  3  current FSM state code

Behaviour:
- One clock `clock`; `clear` is synchronous and active-high.
- States: HG=0 (hwy G, cntry R), HY=1 (hwy Y), AR=2 (all red), CG=3 (cntry G), CY=4 (cntry Y), PW=5 (all red, walk=1), PC=6 (all red). Code 7 is unreachable and recovers to HG.
- Outputs are a pure decode of the registered state: hwy/cntry/walk/phase change the cycle after the transition edge.
- tmr counts cycles in the current state. It resets to 0 on every transition and saturates at all-ones. A state of duration N exits on the edge where tmr==N-1.
- HG → HY when tmr ≥ MIN_GREEN-1 and (car_cntry | ped_pending).
  - On that edge the target is latched: country only → CNTRY; ped only → PED; both → the one not equal to last_served.
- HY → AR after y2rdelay cycles.
- AR → CG if target=CNTRY, → PW if target=PED, after r2gdelay cycles.
- CG → CY when car_cntry=0 or tmr==MAX_CNTRY_GREEN-1. last_served←CNTRY on CG entry.
- CY → PC after y2rdelay cycles.
- PW → PC after WALK_TIME cycles. last_served←PED on PW entry.
- PC → HG after r2gdelay cycles. The highway always regains green between services.
- ped_pending: set on any cycle ped_req=1 except while in PW. Cleared on the PW-entry edge; a ped_req on that edge is also dropped. Held through all other states.
- car_cntry is not latched. If it drops before CG entry, CG lasts exactly 1 cycle.
- Delay inputs are sampled continuously. A change mid-phase takes effect against the current tmr, so a phase ends immediately if tmr already ≥ new N-1.
- clear at any time: next edge gives state=HG, tmr=0, ped_pending=0, last_served=PED (country wins the first tie). Outputs become hwy=2, cntry=0, walk=0, phase=0.
- Never hwy≠RED and cntry≠RED simultaneously. walk=1 only when both heads are RED.

Optional Feature:
TSC_PREEMPT_EN
- Defined: adds input `preempt` (1 bit, emergency vehicle on highway). While preempt=1:
  - HG never exits; tmr keeps counting.
  - CG → CY on the next edge regardless of tmr or car_cntry.
  - PW → PC on the next edge.
  - HY, AR, CY and PC complete normally, except AR goes to PC instead of CG/PW. The target stays pending.
  - Requests keep latching.
- Not defined: the port is absent and behaviour is as above.

Test Plan:
1. Reset: MIN_GREEN=4, MAX_CNTRY_GREEN=8, WALK_TIME=6, y2rdelay=3, r2gdelay=2. clear=1 for 5 negedges → hwy=2, cntry=0, walk=0, phase=0, ped_pending=0; no change for 15 idle cycles.
2. car_cntry=1 at cycle 20 for 10 cycles → HY 3 cycles, AR 2, CG until car drops (~5 cycles), CY 3 (cntry=1), PC 2, then hwy=2.
3. car_cntry held 30 cycles → CG exactly 8 cycles then CY despite car=1; HG for 4 cycles, then served again.
4. Single-cycle ped_req in HG at tmr≥3 → ped_pending=1 next cycle; HY 3, AR 2, walk=1 for 6 cycles (ped_pending drops at PW entry), PC 2, HG. ped_req during PW is ignored.
5. car_cntry=1 and ped_req pulse both in HG after reset → CG first, then HG 4 cycles, then PW. Repeat both → CG again (round-robin alternates).
6. y2rdelay=0, r2gdelay=0 → yellow and all-red each last 1 cycle. clear asserted mid-CG → HG/hwy=2 on the next cycle, ped_pending=0.
